// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the {pc, instr} entry carried through the fetch queue.
package fetch_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: PC, instruction-memory and decode-side signals of the fetch stage.
interface instr_fetch_queue_if;
  import fetch_pkg::*;
  logic [AW-1:0] pc_addr;
  logic          pc_advance;
  logic          flush;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  modport master (
    input  pc_addr, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output pc_advance, imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
  );
  modport slave (
    output pc_addr, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  pc_advance, imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with clear; push is accepted when full only alongside a pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge i_clk)
    if (w_push && !i_clear) r_mem[r_wr] <= i_wdata;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: credit-limited in-order imem fetch with a prefetch queue toward decode.
// Flush empties the queue and arms a discard count covering every request still at the memory.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  instr_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;
  fetch_entry_t  w_head, w_entry;
  logic [AW-1:0] w_f_addr;
  logic [CW-1:0] w_q_count, w_f_count, r_discard;
  logic [UW-1:0] w_used;
  logic w_q_empty, w_q_full, w_f_empty, w_f_full;
  logic w_req_valid, w_hs, w_drop, w_q_push, w_q_pop;
  assign w_used      = {1'b0, w_q_count} + {1'b0, w_f_count};
  assign w_req_valid = i_rst_n & ~bus.flush & (w_used < UW'(DEPTH));
  assign w_hs        = w_req_valid & bus.imem_req_ready;
  assign w_drop      = bus.flush | (r_discard != '0);
  assign w_q_push    = bus.imem_rsp_valid & ~w_drop;
  assign w_q_pop     = ~w_q_empty & bus.instr_ready & ~bus.flush;
  assign w_entry     = '{pc: w_f_addr, instr: bus.imem_rsp_data};
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = bus.pc_addr;
  assign bus.pc_advance     = w_hs;
  assign bus.instr_valid    = ~w_q_empty;
  assign bus.instr_pc       = w_q_empty ? '0 : w_head.pc;
  assign bus.instr_data     = w_q_empty ? '0 : w_head.instr;
  // Every response, kept or dropped, retires the oldest outstanding address.
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(AW)) u_inflight (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_hs),
    .i_pop   (bus.imem_rsp_valid),
    .i_clear (1'b0),
    .i_wdata (bus.pc_addr),
    .o_rdata (w_f_addr),
    .o_full  (w_f_full),
    .o_empty (w_f_empty),
    .o_count (w_f_count)
  );
  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_q_push),
    .i_pop   (w_q_pop),
    .i_clear (bus.flush),
    .i_wdata (w_entry),
    .o_rdata (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_discard <= '0;
    else if (bus.flush) r_discard <= w_f_count - CW'(bus.imem_rsp_valid);
    else if (bus.imem_rsp_valid && r_discard != '0) r_discard <= r_discard - CW'(1);
`ifndef SYNTHESIS
  a_rsp_into_full: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_q_push && w_q_full));
  a_rsp_no_req: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(bus.imem_rsp_valid && w_f_empty));
  a_req_overrun: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_hs && w_f_full));
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: random PC/memory/decode traffic scored against an epoch-tagged request model.
module tb_instr_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [AW-1:0] pc;
    int            epoch;
    int            due;
  } req_t;
  logic clk = 0, rst_n = 0;
  instr_fetch_queue_if bus();
  instr_fetch_queue #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0, epoch = 0;
  int p_rdy = 100, p_mrdy = 100, p_fl = 0, lat_max = 1, mq;
  bit toggle = 0;
  logic mev, cap_hs = 0, cap_flush = 0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] exp_q[$];
  req_t pend[$];
  function automatic logic [DW-1:0] memf(logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  function automatic int live();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) n++;
    return n;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // Monitor: decode sees exactly the post-flush requests, in order, each with its memory word.
  always @(negedge clk) begin
    if (!rst_n) begin
      cap_hs = 0;
      cap_flush = 0;
    end else begin
      mq  = exp_q.size() - live();
      mev = (mq + pend.size() < DEPTH) && !bus.flush;
      chk("req_valid", bus.imem_req_valid, mev);
      chk("pc_advance", bus.pc_advance, mev & bus.imem_req_ready);
      chk("req_addr", bus.imem_req_addr, pc);
      chk("instr_valid", bus.instr_valid, mq > 0);
      if (mq > 0) begin
        chk("instr_pc", bus.instr_pc, exp_q[0]);
        chk("instr_data", bus.instr_data, memf(exp_q[0]));
      end
      cap_hs = mev & bus.imem_req_ready;
      cap_flush = bus.flush;
      if (bus.flush) exp_q.delete();
      else if (mq > 0 && bus.instr_ready) void'(exp_q.pop_front());
    end
  end
  task automatic step();
    @(posedge clk);
    cyc++;
    if (bus.imem_rsp_valid) pend.delete(0);
    if (cap_hs) begin
      pend.push_back('{pc, epoch, cyc + int'($urandom_range(0, lat_max - 1))});
      exp_q.push_back(pc);
      pc += 4;
    end
    if (cap_flush) begin
      epoch++;
      pc = 32'($urandom_range(0, 1023)) << 2;
    end
    #1;
    bus.pc_addr        = pc;
    bus.flush          = $urandom_range(0, 99) < p_fl;
    bus.imem_req_ready = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 99) < p_mrdy);
    bus.instr_ready    = $urandom_range(0, 99) < p_rdy;
    bus.imem_rsp_valid = pend.size() > 0 && pend[0].due <= cyc;
    bus.imem_rsp_data  = bus.imem_rsp_valid ? memf(pend[0].pc) : '0;
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  task automatic check_reset_outputs(string tag);
    chk({tag, "_instr_valid"}, bus.instr_valid, 0);
    chk({tag, "_req_valid"}, bus.imem_req_valid, 0);
    chk({tag, "_pc_advance"}, bus.pc_advance, 0);
    chk({tag, "_instr_data"}, bus.instr_data, 0);
    chk({tag, "_instr_pc"}, bus.instr_pc, 0);
  endtask
  initial begin
    bus.pc_addr = '0;
    bus.flush = 0;
    bus.imem_req_ready = 1;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data = '0;
    bus.instr_ready = 1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk);
    #1 rst_n = 1;
    run(20);
    p_rdy = 0;
    run(12);
    p_rdy = 100;
    run(10);
    p_fl = 10; p_rdy = 70; lat_max = 3;
    run(150);
    p_fl = 0; toggle = 1; lat_max = 2;
    run(60);
    toggle = 0; p_mrdy = 60; p_rdy = 60; p_fl = 5; lat_max = 4;
    run(300);
    p_fl = 0; p_mrdy = 100; p_rdy = 0; lat_max = 1;
    run(12);
    @(posedge clk);
    #3;
    chk("full_before_reset", bus.instr_valid, 1);
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    pend.delete();
    exp_q.delete();
    pc = '0;
    epoch++;
    bus.pc_addr = '0;
    bus.flush = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    @(posedge clk);
    #1 rst_n = 1;
    p_rdy = 100;
    run(30);
    p_mrdy = 70; p_rdy = 70; p_fl = 8; lat_max = 3;
    run(200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
